// File: rtl/fp_multiplier.sv
// ---------------------------------------------------------------------------
// FpMultiplier : multi-cycle IEEE-754 single-precision multiplier.
//
// Purpose
//   Multiplies two single-precision operands through a fixed seven-state
//   sequence (IDLE, UNPACK, SPECIAL, MULTIPLY, NORMALISE, ROUND, PACK).
//   Every operand class takes the same path, so the latency is always six
//   cycles from the accepting edge to the edge that raises done.
//   Denormal inputs are read as signed zero. Results that underflow are
//   flushed to signed zero, and results that overflow become signed infinity.
//
// Ports
//   clk      : single clock, rising-edge active
//   rst      : synchronous active-high reset
//   input_a  : 32-bit multiplicand, captured on the accepting edge
//   input_b  : 32-bit multiplier, captured on the accepting edge
//   start    : request, sampled only in IDLE
//   output_z : 32-bit product, held until the next result
//   done     : one-cycle pulse, raised in the cycle output_z updates
//   busy     : high from accept through the done cycle
//
// Configuration
//   FP_MUL_RNE_EN : when defined, ROUND applies round-to-nearest-even.
//                   When undefined (default), ROUND truncates.
// ---------------------------------------------------------------------------
module fp_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    input  logic        start,
    output logic [31:0] output_z,
    output logic        done,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, UNPACK, SPECIAL, MULTIPLY, NORMALISE, ROUND, PACK
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [31:0]       r_a, r_b;
    logic              r_signA, r_signB, r_sign;
    logic [7:0]        r_expA, r_expB;
    logic [23:0]       r_mantA, r_mantB;
    logic              r_isSpecial;
    logic [31:0]       r_specialZ;
    logic [47:0]       r_prod;
    logic signed [9:0] r_exp;
    logic              r_lostBit;
    logic [22:0]       r_fracR;
    logic signed [9:0] r_expR;
    logic [31:0]       r_outputZ;
    logic              r_done;
    logic              r_busy;

    logic        w_nanA, w_nanB, w_infA, w_infB, w_zeroA, w_zeroB;
    logic [23:0] w_sig;
    logic        w_guard, w_round, w_sticky;
    logic        w_roundUp;
    logic [24:0] w_sum;

    assign output_z = r_outputZ;
    assign done     = r_done;
    assign busy     = r_busy;

    // State register. Reset returns to IDLE, which drops any operation that is
    // still in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. The only branch is in IDLE. After that the sequence
    // always runs straight through, so the latency does not depend on the data.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:      w_nextState = start ? UNPACK : IDLE;
            UNPACK:    w_nextState = SPECIAL;
            SPECIAL:   w_nextState = MULTIPLY;
            MULTIPLY:  w_nextState = NORMALISE;
            NORMALISE: w_nextState = ROUND;
            ROUND:     w_nextState = PACK;
            PACK:      w_nextState = IDLE;
            default:   w_nextState = IDLE;
        endcase
    end

    // Operand classification used in SPECIAL. The unpacked significand keeps the
    // raw fraction for exponent 255, so NaN and infinity can still be told apart.
    always_comb begin
        w_nanA  = (r_expA == 8'hFF) && (r_mantA[22:0] != 23'd0);
        w_nanB  = (r_expB == 8'hFF) && (r_mantB[22:0] != 23'd0);
        w_infA  = (r_expA == 8'hFF) && (r_mantA[22:0] == 23'd0);
        w_infB  = (r_expB == 8'hFF) && (r_mantB[22:0] == 23'd0);
        w_zeroA = (r_expA == 8'd0);
        w_zeroB = (r_expB == 8'd0);
    end

    // Rounding inputs. After NORMALISE the leading one sits at bit 46. The
    // 24-bit result is bits 46..23 and guard/round come from the next two bits.
    // Sticky also folds in the bit that may have been shifted out in NORMALISE.
    always_comb begin
        w_sig    = r_prod[46:23];
        w_guard  = r_prod[22];
        w_round  = r_prod[21];
        w_sticky = (|r_prod[20:0]) | r_lostBit;
`ifdef FP_MUL_RNE_EN
        w_roundUp = w_guard & (w_round | w_sticky | w_sig[0]);
`else
        w_roundUp = 1'b0;
`endif
        w_sum = {1'b0, w_sig} + {24'd0, w_roundUp};
    end

`ifndef FP_MUL_RNE_EN
    // Truncation ignores the rounding bits. This reduction only marks them as
    // intentionally unused.
    logic w_unusedRoundBits;
    assign w_unusedRoundBits = w_guard ^ w_round ^ w_sticky;
`endif

    // Datapath and output registers. Each state does its one step of the
    // operation. A special-case result is decided in SPECIAL and is only
    // selected in PACK, so the later stages can run on don't-care data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outputZ <= 32'd0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= start;
                    if (start) begin
                        r_a <= input_a;
                        r_b <= input_b;
                    end
                end
                UNPACK: begin
                    r_signA <= r_a[31];
                    r_signB <= r_b[31];
                    r_expA  <= r_a[30:23];
                    r_expB  <= r_b[30:23];
                    r_mantA <= (r_a[30:23] == 8'd0) ? 24'd0 : {1'b1, r_a[22:0]};
                    r_mantB <= (r_b[30:23] == 8'd0) ? 24'd0 : {1'b1, r_b[22:0]};
                end
                SPECIAL: begin
                    r_sign      <= r_signA ^ r_signB;
                    r_isSpecial <= 1'b1;
                    if (w_nanA || w_nanB) begin
                        r_specialZ <= 32'h7FC00000;
                    end else if ((w_infA && w_zeroB) || (w_infB && w_zeroA)) begin
                        r_specialZ <= 32'h7FC00000;
                    end else if (w_infA || w_infB) begin
                        r_specialZ <= {r_signA ^ r_signB, 8'hFF, 23'd0};
                    end else if (w_zeroA || w_zeroB) begin
                        r_specialZ <= {r_signA ^ r_signB, 31'd0};
                    end else begin
                        r_isSpecial <= 1'b0;
                        r_specialZ  <= 32'd0;
                    end
                end
                MULTIPLY: begin
                    r_prod <= {24'd0, r_mantA} * {24'd0, r_mantB};
                    r_exp  <= $signed({2'b00, r_expA}) + $signed({2'b00, r_expB})
                              - 10'sd127;
                end
                NORMALISE: begin
                    // The product of two normalised significands lies in
                    // [2^46, 2^48), so at most one right shift is needed.
                    if (r_prod[47]) begin
                        r_prod    <= r_prod >> 1;
                        r_exp     <= r_exp + 10'sd1;
                        r_lostBit <= r_prod[0];
                    end else begin
                        r_lostBit <= 1'b0;
                    end
                end
                ROUND: begin
                    // A carry out of the significand leaves it at exactly 1.0,
                    // so shifting it down by one gives a zero fraction.
                    if (w_sum[24]) begin
                        r_fracR <= w_sum[23:1];
                        r_expR  <= r_exp + 10'sd1;
                    end else begin
                        r_fracR <= w_sum[22:0];
                        r_expR  <= r_exp;
                    end
                end
                PACK: begin
                    r_done <= 1'b1;
                    if (r_isSpecial) begin
                        r_outputZ <= r_specialZ;
                    end else if (r_expR >= 10'sd255) begin
                        r_outputZ <= {r_sign, 8'hFF, 23'd0};
                    end else if (r_expR <= 10'sd0) begin
                        r_outputZ <= {r_sign, 31'd0};
                    end else begin
                        r_outputZ <= {r_sign, r_expR[7:0], r_fracR};
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_multiplier.sv
// ---------------------------------------------------------------------------
// TbFpMultiplier : self-checking bench for fp_multiplier.
// When an operation is accepted, the bench pushes the expected product and
// the cycle in which done should appear onto a scoreboard queue. A monitor
// on the falling edge pops the queue whenever done is seen. Expected values
// come either from the directed constants or from an integer reference model.
// ---------------------------------------------------------------------------
module tb_fp_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] input_a;
    logic [31:0] input_b;
    wire  [31:0] output_z;
    wire         done;
    wire         busy;

    typedef struct {
        logic [31:0] z;
        int          doneCycle;
    } exp_t;

    exp_t expQ[$];
    int   cycleCount = 0;
    int   checkCount = 0;
    int   errorCount = 0;

    fp_multiplier dut (
        .clk      (clk),
        .rst      (rst),
        .input_a  (input_a),
        .input_b  (input_b),
        .start    (start),
        .output_z (output_z),
        .done     (done),
        .busy     (busy)
    );

    // Free-running clock, plus a cycle counter used to check done timing.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // Single comparison point. Every check goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Integer reference model. It finds the leading one of the full product,
    // splits the product into a kept part and a remainder, and rounds by
    // comparing the remainder with half an ulp.
    function automatic logic [31:0] modelMul(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        int                ea, eb, e, shift;
        longint unsigned   prod, mant, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
        if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FC00000;
        if (ea == 255 || eb == 255) return {s, 8'hFF, 23'd0};
        if (ea == 0 || eb == 0) return {s, 31'd0};
        prod = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        e = ea + eb - 127;
        if (prod >= (64'd1 << 47)) begin
            shift = 24;
            e = e + 1;
        end else begin
            shift = 23;
        end
        mant = prod >> shift;
        rem  = prod - (mant << shift);
        half = 64'd1 << (shift - 1);
`ifdef FP_MUL_RNE_EN
        if (rem > half || (rem == half && (mant & 64'd1) == 64'd1)) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e = e + 1;
        end
`else
        if (rem > half) mant = mant;
`endif
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), 23'(mant)};
    endfunction

    // Scoreboard monitor. Every done pulse must match the head of the queue,
    // both in value and in the cycle it appears.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_done", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("result", output_z, e.z);
                checkOutput("done_cycle", 32'(cycleCount), 32'(e.doneCycle));
                checkOutput("busy_in_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    // Presents one operation and pushes its expected result. Afterwards the
    // operands are scrambled to show they were captured on the accepting edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expected);
        exp_t e;
        @(negedge clk);
        input_a = a;
        input_b = b;
        start   = 1'b1;
        @(posedge clk);
        #1;
        e.z         = expected;
        e.doneCycle = cycleCount + 6;
        expQ.push_back(e);
        start   = 1'b0;
        input_a = $urandom;
        input_b = $urandom;
        checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // Waits for the scoreboard to empty, with a cycle bound, then checks that
    // busy has dropped.
    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
        @(negedge clk);
        @(negedge clk);
        checkOutput("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int k;
        exp_t e;
        logic [31:0] a, b;
        rst     = 1'b1;
        start   = 1'b0;
        input_a = 32'd0;
        input_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_z", output_z, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Start held high: three results, spaced seven cycles apart. A start
        // seen while busy must not disturb this spacing.
        @(negedge clk);
        input_a = 32'h40AE0000;
        input_b = 32'hBEC00000;
        start   = 1'b1;
        @(posedge clk);
        #1;
        k = cycleCount;
        for (int i = 0; i < 3; i++) begin
            e.z         = 32'hC0028000;
            e.doneCycle = k + 7 * i + 6;
            expQ.push_back(e);
        end
        repeat (14) @(posedge clk);
        #1;
        start = 1'b0;
        waitDrain();

        // Directed cases with known answers.
        applyStimulus(32'h40000000, 32'h40400000, 32'h40C00000); waitDrain();
        applyStimulus(32'h7F800000, 32'h00000000, 32'h7FC00000); waitDrain();
        applyStimulus(32'h7F000000, 32'h40000000, 32'h7F800000); waitDrain();
`ifdef FP_MUL_RNE_EN
        applyStimulus(32'h3F800001, 32'h3FC00000, 32'h3FC00002); waitDrain();
`else
        applyStimulus(32'h3F800001, 32'h3FC00000, 32'h3FC00001); waitDrain();
`endif
        applyStimulus(32'h7FC00001, 32'h3F800000, 32'h7FC00000); waitDrain();
        applyStimulus(32'hFF800000, 32'h40000000, 32'hFF800000); waitDrain();
        applyStimulus(32'h80000001, 32'h3F800000, 32'h80000000); waitDrain();
        applyStimulus(32'h00800000, 32'h00800000, 32'h00000000); waitDrain();
        applyStimulus(32'h3FFFFFFF, 32'h3F800001, modelMul(32'h3FFFFFFF, 32'h3F800001));
        waitDrain();

        // Reset arrives three cycles after the accept. No done may follow,
        // and a start in the very next cycle must be taken.
        @(negedge clk);
        input_a = 32'h40000000;
        input_b = 32'h40000000;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midreset_z", output_z, 32'd0);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_done", {31'd0, done}, 32'd0);
        applyStimulus(32'h40400000, 32'h40400000, 32'h41100000);
        waitDrain();

        // Random operands, mostly normal values in a moderate exponent range,
        // with every fourth pair fully random.
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) begin
                a = $urandom;
                b = $urandom;
            end else begin
                a = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
                b = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            end
            applyStimulus(a, b, modelMul(a, b));
            waitDrain();
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
